// File: rtl/signal_stats.sv
// signal_stats
// ------------
// Measurement stage that sits after trigger_rom. On a start pulse it walks the
// captured display buffer one sample per clock. It then publishes registered
// max / min / mean / peak-to-peak values for font_gen.
//
// Ports:
//   clk         pixel-domain clock (shared with the VGA pipeline)
//   rst         synchronous, active-high reset
//   start       single-cycle request to measure the current buffer
//   data        N_SAMPLES x DATA_W unpacked sample buffer (held stable while busy)
//   busy        high while a scan (SCAN or FINAL) is in progress
//   done        one-cycle pulse when the result registers update
//   valid       high once at least one scan has completed since reset
//   max_bin     largest sample of the last completed scan
//   min_bin     smallest sample of the last completed scan
//   mea_bin     truncated mean of the last completed scan
//   ptp_bin     max_bin - min_bin
//   period_bin  distance between the first two rising crossings
//               (only when SIGNAL_STATS_PERIOD_EN is defined)
//
// Optional feature macro: SIGNAL_STATS_PERIOD_EN
//   When this macro is defined, the block also measures the signal period.
//   A rising crossing is counted against a threshold. That threshold is the
//   midpoint of the previous completed scan, or mid-scale after reset.

module signal_stats #(
  parameter int N_SAMPLES = 256,
  parameter int DATA_W    = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] data [0:N_SAMPLES-1],
  output logic              busy,
  output logic              done,
  output logic              valid,
  output logic [DATA_W-1:0] max_bin,
  output logic [DATA_W-1:0] min_bin,
  output logic [DATA_W-1:0] mea_bin,
  output logic [DATA_W-1:0] ptp_bin
`ifdef SIGNAL_STATS_PERIOD_EN
  ,
  output logic [DATA_W-1:0] period_bin
`endif
);

  localparam int IDX_W = $clog2(N_SAMPLES);
  // Wide enough to sum N_SAMPLES full-scale samples without overflow.
  localparam int ACC_W = DATA_W + IDX_W;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_SAMPLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    FINAL
  } state_t;

  state_t            state;
  state_t            next_state;
  logic [IDX_W-1:0]  idx;
  logic [ACC_W-1:0]  acc;
  logic [DATA_W-1:0] run_min;
  logic [DATA_W-1:0] run_max;
  logic [DATA_W-1:0] sample;
  logic              scan_go;

  assign sample = data[idx];

  // A start is accepted only from IDLE. It is also refused while done is
  // still high, so a request that arrives as the previous result is being
  // published gets dropped instead of being queued.
  assign scan_go = (state == IDLE) && start && !done;

  assign busy = (state != IDLE);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (scan_go) next_state = SCAN;
      SCAN:    if (idx == LAST_IDX) next_state = FINAL;
      FINAL:   next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Main datapath. The running statistics are seeded when a scan is accepted.
  // They are updated once per sample while in SCAN. The running min starts at
  // all-ones so that the first sample always replaces it. The public result
  // registers only change in FINAL, which keeps them steady between scans.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx     <= '0;
      acc     <= '0;
      run_min <= '1;
      run_max <= '0;
      max_bin <= '0;
      min_bin <= '0;
      mea_bin <= '0;
      ptp_bin <= '0;
      done    <= 1'b0;
      valid   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (scan_go) begin
            idx     <= '0;
            acc     <= '0;
            run_min <= '1;
            run_max <= '0;
          end
        end
        SCAN: begin
          acc <= acc + ACC_W'(sample);
          if (sample < run_min) run_min <= sample;
          if (sample > run_max) run_max <= sample;
          idx <= idx + IDX_W'(1);
        end
        FINAL: begin
          max_bin <= run_max;
          min_bin <= run_min;
          // The buffer depth is a power of two, so the mean is just the
          // upper bits of the accumulator.
          mea_bin <= acc[ACC_W-1:IDX_W];
          ptp_bin <= run_max - run_min;
          done    <= 1'b1;
          valid   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef SIGNAL_STATS_PERIOD_EN
  logic [DATA_W-1:0] thr;
  logic [DATA_W-1:0] prev_sample;
  logic [IDX_W-1:0]  first_x;
  logic [IDX_W-1:0]  second_x;
  logic [1:0]        x_cnt;
  logic [DATA_W:0]   mid_sum;

  assign mid_sum = {1'b0, run_max} + {1'b0, run_min};

  // Period measurement. The previous sample is delayed by one so that a
  // rising crossing can be seen as prev < thr <= current. Index 0 has no
  // predecessor, so it is never treated as a crossing. Only the first two
  // crossings are kept. The threshold moves to this scan's midpoint only in
  // FINAL, after the search for this scan is complete. The next scan
  // therefore uses the level of the scan before it.
  always_ff @(posedge clk) begin
    if (rst) begin
      thr         <= DATA_W'(1) << (DATA_W - 1);
      prev_sample <= '0;
      first_x     <= '0;
      second_x    <= '0;
      x_cnt       <= '0;
      period_bin  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (scan_go) begin
            first_x  <= '0;
            second_x <= '0;
            x_cnt    <= '0;
          end
        end
        SCAN: begin
          prev_sample <= sample;
          if ((idx != '0) && (prev_sample < thr) && (sample >= thr)) begin
            if (x_cnt == 2'd0) begin
              first_x <= idx;
              x_cnt   <= 2'd1;
            end else if (x_cnt == 2'd1) begin
              second_x <= idx;
              x_cnt    <= 2'd2;
            end
          end
        end
        FINAL: begin
          period_bin <= (x_cnt == 2'd2) ? DATA_W'(second_x - first_x) : '0;
          thr        <= mid_sum[DATA_W:1];
        end
        default: ;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_signal_stats.sv
// tb_signal_stats
// ---------------
// Self-checking bench for signal_stats. A behavioural model computes the
// statistics of the buffer with plain loops and division. When
// SIGNAL_STATS_PERIOD_EN is defined, the model also finds the crossing
// period from a list of crossing indices. Each scan is compared against the
// model, including its latency and the number of done pulses.

module tb_signal_stats;

  localparam int N  = 256;
  localparam int DW = 12;

  logic          clk;
  logic          rst;
  logic          start;
  logic [DW-1:0] data [0:N-1];
  logic          busy;
  logic          done;
  logic          valid;
  logic [DW-1:0] max_bin;
  logic [DW-1:0] min_bin;
  logic [DW-1:0] mea_bin;
  logic [DW-1:0] ptp_bin;
`ifdef SIGNAL_STATS_PERIOD_EN
  logic [DW-1:0] period_bin;
`endif

  int n_vec;
  int n_err;

  // Reference-model state that persists across scans.
  int model_thr;
  int exp_max, exp_min, exp_mean, exp_ptp, exp_period;

  signal_stats #(.N_SAMPLES(N), .DATA_W(DW)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .data    (data),
    .busy    (busy),
    .done    (done),
    .valid   (valid),
    .max_bin (max_bin),
    .min_bin (min_bin),
    .mea_bin (mea_bin),
    .ptp_bin (ptp_bin)
`ifdef SIGNAL_STATS_PERIOD_EN
    ,
    .period_bin (period_bin)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value with its expected value and count the check.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Compute the expected results for the current buffer from first
  // principles. On a completed scan this also advances the threshold.
  task automatic computeModel();
    int sum;
    int xs[$];
    sum = 0;
    exp_max = 0;
    exp_min = (1 << DW) - 1;
    for (int i = 0; i < N; i++) begin
      sum += int'(data[i]);
      if (int'(data[i]) > exp_max) exp_max = int'(data[i]);
      if (int'(data[i]) < exp_min) exp_min = int'(data[i]);
    end
    exp_mean = sum / N;
    exp_ptp  = exp_max - exp_min;
    for (int i = 1; i < N; i++)
      if (int'(data[i-1]) < model_thr && int'(data[i]) >= model_thr) xs.push_back(i);
    exp_period = (xs.size() >= 2) ? (xs[1] - xs[0]) : 0;
    model_thr  = (exp_max + exp_min) / 2;
  endtask

  // Pulse start, optionally add a second start or a reset at a given cycle
  // offset, then watch 300 edges. The task counts done pulses and checks
  // that the first one lands exactly 257 edges after start is taken.
  task automatic applyStimulus(input int extra_start_cyc, input int reset_cyc);
    int done_seen;
    int first_done;
    done_seen  = 0;
    first_done = -1;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    checkOutput("busy_after_start", {31'd0, busy}, 32'd1);
    for (int cyc = 1; cyc <= 300; cyc++) begin
      @(negedge clk);
      if (cyc == extra_start_cyc) start = 1'b1;
      if (cyc == reset_cyc) rst = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      if (done) begin
        done_seen++;
        if (first_done < 0) first_done = cyc;
      end
      if (cyc == reset_cyc) begin
        rst = 1'b0;
        model_thr = 32'h800;
        checkOutput("rst_busy",  {31'd0, busy},  32'd0);
        checkOutput("rst_done",  {31'd0, done},  32'd0);
        checkOutput("rst_valid", {31'd0, valid}, 32'd0);
        checkOutput("rst_max",   {20'd0, max_bin}, 32'd0);
        checkOutput("rst_min",   {20'd0, min_bin}, 32'd0);
        checkOutput("rst_mea",   {20'd0, mea_bin}, 32'd0);
        checkOutput("rst_ptp",   {20'd0, ptp_bin}, 32'd0);
      end
    end
    if (reset_cyc > 0) begin
      checkOutput("aborted_done_count", done_seen, 32'd0);
    end else begin
      checkOutput("done_count",   done_seen,  32'd1);
      checkOutput("done_latency", first_done, 32'd257);
      computeModel();
      checkOutput("valid", {31'd0, valid}, 32'd1);
      checkOutput("busy_idle", {31'd0, busy}, 32'd0);
      checkOutput("max", {20'd0, max_bin}, exp_max);
      checkOutput("min", {20'd0, min_bin}, exp_min);
      checkOutput("mea", {20'd0, mea_bin}, exp_mean);
      checkOutput("ptp", {20'd0, ptp_bin}, exp_ptp);
`ifdef SIGNAL_STATS_PERIOD_EN
      checkOutput("period", {20'd0, period_bin}, exp_period);
`endif
    end
  endtask

  task automatic fillRandom();
    for (int i = 0; i < N; i++) data[i] = DW'($urandom_range(0, (1 << DW) - 1));
  endtask

  initial begin
    n_vec     = 0;
    n_err     = 0;
    model_thr = 32'h800;
    rst       = 1'b1;
    start     = 1'b0;
    for (int i = 0; i < N; i++) data[i] = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_busy",  {31'd0, busy},  32'd0);
    checkOutput("reset_done",  {31'd0, done},  32'd0);
    checkOutput("reset_valid", {31'd0, valid}, 32'd0);
    checkOutput("reset_max",   {20'd0, max_bin}, 32'd0);
    checkOutput("reset_ptp",   {20'd0, ptp_bin}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Square wave, first frame after reset: crossings at 16 and 48.
    for (int i = 0; i < N; i++) data[i] = ((i / 16) % 2) ? 12'hC00 : 12'h400;
    applyStimulus(-1, -1);
`ifdef SIGNAL_STATS_PERIOD_EN
    checkOutput("square_period_32", {20'd0, period_bin}, 32'd32);
`endif

    // Flat mid-scale buffer.
    for (int i = 0; i < N; i++) data[i] = 12'h800;
    applyStimulus(-1, -1);
    checkOutput("flat_mea", {20'd0, mea_bin}, 32'h800);

    // Ramp 16*i.
    for (int i = 0; i < N; i++) data[i] = DW'(16 * i);
    applyStimulus(-1, -1);
    checkOutput("ramp_mea_2040", {20'd0, mea_bin}, 32'd2040);

    // Single full-scale spike.
    for (int i = 0; i < N; i++) data[i] = '0;
    data[100] = 12'hFFF;
    applyStimulus(-1, -1);
    checkOutput("spike_mea_15", {20'd0, mea_bin}, 32'd15);

    // Random buffers.
    for (int r = 0; r < 4; r++) begin
      fillRandom();
      applyStimulus(-1, -1);
    end

    // A second start in the middle of a scan must be ignored.
    fillRandom();
    applyStimulus(50, -1);

    // Reset in the middle of a scan, then a fresh scan from a clean state.
    fillRandom();
    applyStimulus(-1, 120);
    fillRandom();
    applyStimulus(-1, -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
